spike_mem_ctrl: RTL and testbench
=================================

SPIKE_MEM_CTRL -- requirements
Module: spike_mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 4, spike entry width in bits.
REQ-002 SHALL have parameter NUM_ENTRIES, default 160, logical spike entries; addresses wrap modulo NUM_ENTRIES.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, logical address width.
REQ-004 SHALL have parameter READ_LATENCY, default 2, memory read latency in cycles (1 or 2).
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have host write ports: wr_valid in 1; wr_ready out 1; wr_addr in ADDR_WIDTH; wr_data in RAM_WIDTH.
REQ-007 SHALL have scan control ports: start in 1; abort in 1; mode16 in 1 (1 = 4 entries per beat); base_addr in ADDR_WIDTH; len in ADDR_WIDTH+1 (entry count); busy out 1; done out 1.
REQ-008 SHALL have memory ports: mem_en_port_wr, mem_wr_en, mem_en_port_rd, mem_rd_en out 1; mem_wr_addr, mem_rd_addr out ADDR_WIDTH; mem_wr_data out RAM_WIDTH; mem_dout4 in RAM_WIDTH; mem_dout16 in 4*RAM_WIDTH.
REQ-009 SHALL have stream ports: spk_valid out 1; spk_ready in 1; spk_data out 4*RAM_WIDTH; spk_last out 1.

Function
REQ-010 States SHALL be IDLE, SCAN, DRAIN; done SHALL pulse one cycle on DRAIN->IDLE.
REQ-011 wr_ready SHALL equal (state==IDLE); an accepted write (wr_valid&wr_ready) SHALL drive mem_wr_en=1, mem_en_port_wr=1, address/data combinationally that cycle.
REQ-012 start SHALL be accepted only in IDLE; start in other states SHALL be ignored; simultaneous write and start in IDLE SHALL both be accepted, the write completing before the first read issue.
REQ-013 On start, controller SHALL latch base_addr (low 2 bits forced 00 when mode16), mode16, and beat count = len (mode4) or ceil(len/4) (mode16).
REQ-014 len=0 SHALL go IDLE->DRAIN->IDLE with done pulse and no spk_valid.
REQ-015 In SCAN a read SHALL issue (mem_rd_en=mem_en_port_rd=1) only when in-flight reads plus FIFO occupancy < 4; address SHALL advance by 1 (mode4) or 4 (mode16), wrapping modulo NUM_ENTRIES.
REQ-016 After the final issue SCAN SHALL go DRAIN; DRAIN SHALL exit when no read is in flight and FIFO is empty.
REQ-017 Read data SHALL be captured into a 4-entry output FIFO exactly READ_LATENCY cycles after issue, tracked by a valid/last shift pipeline.
REQ-018 mode4 beat SHALL put mem_dout4 in spk_data[RAM_WIDTH-1:0], upper bits zero; mode16 beat SHALL pass mem_dout16 unchanged.
REQ-019 spk_last SHALL be asserted with the final beat only; a beat transfers on spk_valid&spk_ready; spk_data SHALL hold while spk_valid&~spk_ready.
REQ-020 FIFO SHALL never overflow under any spk_ready pattern; issue SHALL stall while full credit is reached.
REQ-021 abort SHALL, next cycle, force IDLE, flush FIFO, discard in-flight data, clear pipeline, not pulse done.
REQ-022 busy SHALL equal (state!=IDLE).

Reset
REQ-023 On rst: state IDLE; busy, done, spk_valid, spk_last, mem_wr_en, mem_rd_en, mem_en_port_rd 0; addresses and spk_data 0; FIFO and pipeline cleared.
REQ-024 rst mid-scan SHALL discard all in-flight reads; memory contents unaffected.

Structure
REQ-025 Package estu_spike_pkg SHALL hold the state enum, FIFO_DEPTH=4, default READ_LATENCY.
REQ-026 Output buffer SHALL be sub-module spike_out_fifo (synchronous, 4 entries, count output).

Verification
REQ-027 Write 0xA to addr 5, then start mode4 base 5 len 1, spk_ready=1 -> one beat spk_data=0x000A, spk_last=1, done pulse, first issue to beat = READ_LATENCY+1 cycles.
REQ-028 mode16 base 6 len 8, entries 4..11 preloaded 0..7 -> base forced 4; beats 0x0123 then 0x4567, last on second.
REQ-029 mode4 base 158 len 4 -> read addresses 158,159,0,1 in order.
REQ-030 len 16 mode4, spk_ready toggled 1-in-3 cycles -> 16 beats in order, no loss/duplicate, in-flight+occupancy never >4.
REQ-031 abort at 5th issue of a len 20 scan -> IDLE next cycle, no further spk_valid, no done; new start then runs normally.
REQ-032 wr_valid held during SCAN -> wr_ready=0, no mem_wr_en until IDLE, then write accepted.

Source files
------------

// File: rtl/estu_spike_pkg.sv
// estu_spike_pkg: shared state encoding and sizing constants for the spike memory controller
package estu_spike_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  localparam int FIFO_DEPTH = 4;
  localparam int DEF_READ_LATENCY = 2;
endpackage

// File: rtl/spike_out_fifo.sv
// spike_out_fifo: 4-entry synchronous output buffer (push/pop/flush, dout = head, count = occupancy)
module spike_out_fifo
  import estu_spike_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               push,
  input  logic [WIDTH-1:0]                   din,
  input  logic                               pop,
  output logic [WIDTH-1:0]                   dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/spike_mem_ctrl.sv
// spike_mem_ctrl: host write port plus credit-limited scan of spike memory into a beat stream (clk, rst, host wr_*, scan start/abort/mode16/base_addr/len/busy/done, mem_* port, spk_* stream)
module spike_mem_ctrl
  import estu_spike_pkg::*;
#(
  parameter int RAM_WIDTH    = 4,
  parameter int NUM_ENTRIES  = 160,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [RAM_WIDTH-1:0]    wr_data,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mode16,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     len,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_en_port_wr,
  output logic                    mem_wr_en,
  output logic                    mem_en_port_rd,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  output logic [RAM_WIDTH-1:0]    mem_wr_data,
  input  logic [RAM_WIDTH-1:0]    mem_dout4,
  input  logic [4*RAM_WIDTH-1:0]  mem_dout16,
  output logic                    spk_valid,
  input  logic                    spk_ready,
  output logic [4*RAM_WIDTH-1:0]  spk_data,
  output logic                    spk_last
);
  localparam int DW  = 4*RAM_WIDTH;
  localparam int AW1 = ADDR_WIDTH+1;
  localparam int AW2 = ADDR_WIDTH+2;
  state_t state;
  logic m16, issue, wr_acc, push, pop;
  logic [ADDR_WIDTH-1:0] addr, next_addr;
  logic [AW1-1:0] beats, step_addr;
  logic [READ_LATENCY-1:0] pv, pl;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fcount;
  logic [3:0] credit;
  logic [DW:0] push_word, pop_word;
  always_comb begin
    wr_acc = wr_valid && state == IDLE;
    // credit covers reads still in the memory pipeline plus beats already buffered
    credit = 4'(fcount) + 4'($countones(pv));
    issue = state == SCAN && beats != '0 && credit < 4'(FIFO_DEPTH);
    step_addr = {1'b0, addr} + (m16 ? AW1'(4) : AW1'(1));
    next_addr = ADDR_WIDTH'(step_addr >= AW1'(NUM_ENTRIES) ? step_addr - AW1'(NUM_ENTRIES) : step_addr);
    push = pv[READ_LATENCY-1];
    push_word = {pl[READ_LATENCY-1], m16 ? mem_dout16 : DW'(mem_dout4)};
    pop = spk_valid && spk_ready;
  end
  assign wr_ready       = state == IDLE;
  assign busy           = state != IDLE;
  assign mem_wr_en      = wr_acc;
  assign mem_en_port_wr = wr_acc;
  assign mem_wr_addr    = wr_acc ? wr_addr : '0;
  assign mem_wr_data    = wr_acc ? wr_data : '0;
  assign mem_rd_en      = issue;
  assign mem_en_port_rd = issue;
  assign mem_rd_addr    = addr;
  assign spk_valid      = fcount != '0;
  assign spk_data       = pop_word[DW-1:0];
  assign spk_last       = spk_valid && pop_word[DW];
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= IDLE;
      done <= 1'b0;
      m16 <= 1'b0;
      addr <= '0;
      beats <= '0;
      pv <= '0;
      pl <= '0;
    end else begin
      done <= 1'b0;
      pv <= (pv << 1) | READ_LATENCY'(issue);
      pl <= (pl << 1) | READ_LATENCY'(issue && beats == AW1'(1));
      case (state)
        IDLE: if (start) begin
          m16 <= mode16;
          addr <= mode16 ? {base_addr[ADDR_WIDTH-1:2], 2'b00} : base_addr;
          beats <= mode16 ? AW1'((AW2'(len) + AW2'(3)) >> 2) : len;
          state <= len == '0 ? DRAIN : SCAN;
        end
        SCAN: if (issue) begin
          addr <= next_addr;
          beats <= beats - AW1'(1);
          if (beats == AW1'(1)) state <= DRAIN;
        end
        DRAIN: if (pv == '0 && fcount == '0) begin
          state <= IDLE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  spike_out_fifo #(.WIDTH(DW+1)) u_fifo (
    .clk(clk), .rst(rst), .flush(abort),
    .push(push), .din(push_word),
    .pop(pop), .dout(pop_word), .count(fcount)
  );
endmodule

// File: tb/tb_spike_mem_ctrl.sv
// tb_spike_mem_ctrl: directed bench for spike_mem_ctrl with a latency-2 memory model and stream monitor
module tb_spike_mem_ctrl;
  localparam int RW = 4, NE = 160, AW = 8, RL = 2;
  logic clk = 1'b0, rst;
  logic wr_valid, wr_ready, start, abort, mode16, busy, done;
  logic [AW-1:0] wr_addr, base_addr, mem_wr_addr, mem_rd_addr;
  logic [RW-1:0] wr_data, mem_wr_data, mem_dout4;
  logic [AW:0] len;
  logic mem_en_port_wr, mem_wr_en, mem_en_port_rd, mem_rd_en;
  logic [4*RW-1:0] mem_dout16, spk_data;
  logic spk_valid, spk_ready, spk_last;
  logic rdy_all, rdy_3;
  int cyc = 0, n_checks = 0, n_fail = 0;

  spike_mem_ctrl #(.RAM_WIDTH(RW), .NUM_ENTRIES(NE), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .mode16(mode16), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done),
    .mem_en_port_wr(mem_en_port_wr), .mem_wr_en(mem_wr_en),
    .mem_en_port_rd(mem_en_port_rd), .mem_rd_en(mem_rd_en),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_wr_data(mem_wr_data),
    .mem_dout4(mem_dout4), .mem_dout16(mem_dout16),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_data(spk_data), .spk_last(spk_last)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;
  assign spk_ready = rdy_all | (rdy_3 && cyc % 3 == 0);

  // memory model: two output register stages, 16-bit word = entries a..a+3 with a in the top nibble
  logic [RW-1:0] mm [NE];
  logic [RW-1:0] d4 [RL];
  logic [4*RW-1:0] d16 [RL];
  always @(posedge clk) begin
    if (mem_wr_en && mem_en_port_wr) mm[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en && mem_en_port_rd) begin
      d4[0] <= mm[mem_rd_addr];
      d16[0] <= {mm[mem_rd_addr], mm[(mem_rd_addr+1)%NE], mm[(mem_rd_addr+2)%NE], mm[(mem_rd_addr+3)%NE]};
    end
    d4[1] <= d4[0];
    d16[1] <= d16[0];
  end
  assign mem_dout4 = d4[RL-1];
  assign mem_dout16 = d16[RL-1];

  logic [4*RW-1:0] beats[$];
  logic lasts[$];
  int beat_at[$], iss_at[$];
  logic [AW-1:0] rds[$];
  int done_cnt = 0, valid_cnt = 0, outst = 0, max_out = 0, pcyc = 0;
  always @(posedge clk) begin
    pcyc++;
    if (spk_valid) valid_cnt++;
    if (done) done_cnt++;
    if (mem_rd_en) begin
      rds.push_back(mem_rd_addr);
      iss_at.push_back(pcyc);
    end
    if (spk_valid && spk_ready) begin
      beats.push_back(spk_data);
      lasts.push_back(spk_last);
      beat_at.push_back(pcyc);
    end
    outst = (rst || abort) ? 0 : outst + int'(mem_rd_en) - int'(spk_valid && spk_ready);
    if (outst > max_out) max_out = outst;
  end

  task automatic wr(input int a, input int d);
    wr_valid = 1'b1;
    wr_addr = AW'(a);
    wr_data = RW'(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic go(input logic m, input int b, input int l);
    mode16 = m;
    base_addr = AW'(b);
    len = (AW+1)'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 300 && busy; k++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", nm, busy, k); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (spk_valid !== 1'b0 || spk_last !== 1'b0) begin n_fail++; $display("FAIL reset_stream: valid=%b last=%b want 0 0", spk_valid, spk_last); end
    n_checks++; if (mem_rd_en !== 1'b0 || mem_en_port_rd !== 1'b0 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: rd=%b prd=%b wr=%b want 0 0 0", mem_rd_en, mem_en_port_rd, mem_wr_en); end
    n_checks++; if (spk_data !== 16'h0 || mem_rd_addr !== 8'h0 || mem_wr_addr !== 8'h0) begin n_fail++; $display("FAIL reset_zero: data=%0h rd_addr=%0h wr_addr=%0h want 0", spk_data, mem_rd_addr, mem_wr_addr); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int b0, i0, d0;
    wr(5, 4'hA);
    b0 = beats.size(); i0 = iss_at.size(); d0 = done_cnt;
    rdy_all = 1'b1;
    go(1'b0, 5, 1);
    wait_idle("basic");
    repeat (2) @(negedge clk);
    n_checks++; if (beats.size() - b0 != 1) begin n_fail++; $display("FAIL basic_count: got %0d beats want 1", beats.size() - b0); end
    n_checks++; if (beats[b0] !== 16'h000A) begin n_fail++; $display("FAIL basic_data: got %0h want a", beats[b0]); end
    n_checks++; if (lasts[b0] !== 1'b1) begin n_fail++; $display("FAIL basic_last: got %b want 1", lasts[b0]); end
    n_checks++; if (beat_at[b0] - iss_at[i0] != RL + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", beat_at[b0] - iss_at[i0], RL + 1); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_len0;
    int d0, v0, i0;
    d0 = done_cnt; v0 = valid_cnt; i0 = iss_at.size();
    go(1'b0, 7, 0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL len0_busy: got %b want 1", busy); end
    wait_idle("len0");
    @(negedge clk);
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL len0_done: got %0d want 1", done_cnt - d0); end
    n_checks++; if (valid_cnt != v0 || iss_at.size() != i0) begin n_fail++; $display("FAIL len0_quiet: valid=%0d issues=%0d want 0 0", valid_cnt - v0, iss_at.size() - i0); end
  endtask

  task automatic test_simul_write_start;
    int b0;
    b0 = beats.size();
    wr_valid = 1'b1; wr_addr = 8'd60; wr_data = 4'hC;
    go(1'b0, 60, 1);
    wr_valid = 1'b0;
    wait_idle("simul");
    @(negedge clk);
    n_checks++; if (beats.size() - b0 != 1 || beats[b0] !== 16'h000C) begin n_fail++; $display("FAIL simul_data: got %0h (%0d beats) want c", beats[b0], beats.size() - b0); end
  endtask

  task automatic test_mode16;
    int b0, r0;
    for (int i = 0; i < 8; i++) wr(4 + i, i);
    b0 = beats.size(); r0 = rds.size();
    go(1'b1, 6, 8);
    wait_idle("m16");
    @(negedge clk);
    n_checks++; if (beats.size() - b0 != 2) begin n_fail++; $display("FAIL m16_count: got %0d want 2", beats.size() - b0); end
    n_checks++; if (beats[b0] !== 16'h0123 || beats[b0+1] !== 16'h4567) begin n_fail++; $display("FAIL m16_data: got %0h %0h want 123 4567", beats[b0], beats[b0+1]); end
    n_checks++; if (lasts[b0] !== 1'b0 || lasts[b0+1] !== 1'b1) begin n_fail++; $display("FAIL m16_last: got %b %b want 0 1", lasts[b0], lasts[b0+1]); end
    n_checks++; if (rds[r0] !== 8'd4 || rds[r0+1] !== 8'd8) begin n_fail++; $display("FAIL m16_addr: got %0d %0d want 4 8", rds[r0], rds[r0+1]); end
  endtask

  task automatic test_wrap;
    int b0, r0;
    int exp_a[4] = '{158, 159, 0, 1};
    for (int i = 0; i < 4; i++) wr(exp_a[i], i + 1);
    b0 = beats.size(); r0 = rds.size();
    go(1'b0, 158, 4);
    wait_idle("wrap");
    @(negedge clk);
    n_checks++; if (rds.size() - r0 != 4 || beats.size() - b0 != 4) begin n_fail++; $display("FAIL wrap_count: issues=%0d beats=%0d want 4 4", rds.size() - r0, beats.size() - b0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rds[r0+i] !== AW'(exp_a[i])) begin n_fail++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, rds[r0+i], exp_a[i]); end
      n_checks++; if (beats[b0+i] !== 16'(i + 1) || lasts[b0+i] !== (i == 3)) begin n_fail++; $display("FAIL wrap_beat%0d: got %0h last %b want %0h last %b", i, beats[b0+i], lasts[b0+i], i + 1, i == 3); end
    end
  endtask

  task automatic test_backpressure;
    int b0, d0;
    for (int i = 0; i < 16; i++) wr(20 + i, i);
    b0 = beats.size(); d0 = done_cnt;
    rdy_all = 1'b0; rdy_3 = 1'b1;
    go(1'b0, 20, 16);
    wait_idle("bp");
    @(negedge clk);
    rdy_3 = 1'b0; rdy_all = 1'b1;
    n_checks++; if (beats.size() - b0 != 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", beats.size() - b0); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (beats[b0+i] !== 16'(i) || lasts[b0+i] !== (i == 15)) begin n_fail++; $display("FAIL bp_beat%0d: got %0h last %b want %0h last %b", i, beats[b0+i], lasts[b0+i], i, i == 15); end
    end
    n_checks++; if (max_out != 4) begin n_fail++; $display("FAIL bp_credit: peak outstanding %0d want 4", max_out); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort;
    int i0, b0, v0, d0;
    logic found;
    i0 = iss_at.size(); found = 1'b0;
    rdy_all = 1'b1;
    go(1'b0, 20, 20);
    for (int k = 0; k < 50 && !found; k++) begin
      if (mem_rd_en && iss_at.size() - i0 == 4) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL abort_fifth_issue: seen=%b want 1", found); end
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || spk_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy=%b valid=%b want 0 0", busy, spk_valid); end
    b0 = beats.size(); v0 = valid_cnt;
    repeat (10) @(negedge clk);
    n_checks++; if (valid_cnt != v0 || beats.size() != b0) begin n_fail++; $display("FAIL abort_quiet: valid=%0d beats=%0d want 0 0", valid_cnt - v0, beats.size() - b0); end
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt - d0); end
    go(1'b0, 20, 2);
    wait_idle("abort_rerun");
    @(negedge clk);
    n_checks++; if (beats.size() - b0 != 2 || beats[b0] !== 16'h0 || beats[b0+1] !== 16'h1 || lasts[b0+1] !== 1'b1) begin n_fail++; $display("FAIL abort_rerun: got %0d beats %0h %0h want 2 beats 0 1", beats.size() - b0, beats[b0], beats[b0+1]); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL abort_rerun_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_write_block;
    int b0;
    rdy_all = 1'b0;
    go(1'b0, 20, 8);
    wr_valid = 1'b1; wr_addr = 8'd50; wr_data = 4'h7;
    repeat (6) begin
      @(negedge clk);
      n_checks++; if (wr_ready !== 1'b0 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL wblock_scan: wr_ready=%b mem_wr_en=%b want 0 0", wr_ready, mem_wr_en); end
    end
    rdy_all = 1'b1;
    wait_idle("wblock");
    n_checks++; if (wr_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_en_port_wr !== 1'b1) begin n_fail++; $display("FAIL wblock_accept: wr_ready=%b mem_wr_en=%b port=%b want 1 1 1", wr_ready, mem_wr_en, mem_en_port_wr); end
    n_checks++; if (mem_wr_addr !== 8'd50 || mem_wr_data !== 4'h7) begin n_fail++; $display("FAIL wblock_addr: got %0d/%0h want 50/7", mem_wr_addr, mem_wr_data); end
    @(negedge clk);
    wr_valid = 1'b0;
    b0 = beats.size();
    go(1'b0, 50, 1);
    wait_idle("wblock_read");
    @(negedge clk);
    n_checks++; if (beats.size() - b0 != 1 || beats[b0] !== 16'h0007) begin n_fail++; $display("FAIL wblock_readback: got %0h want 7", beats[b0]); end
  endtask

  task automatic test_reset_mid_scan;
    int b0, v0;
    rdy_all = 1'b0;
    go(1'b0, 20, 8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || spk_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: busy=%b valid=%b want 0 0", busy, spk_valid); end
    rdy_all = 1'b1;
    v0 = valid_cnt;
    repeat (5) @(negedge clk);
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d valid cycles want 0", valid_cnt - v0); end
    b0 = beats.size();
    go(1'b0, 21, 1);
    wait_idle("rstmid_read");
    @(negedge clk);
    n_checks++; if (beats.size() - b0 != 1 || beats[b0] !== 16'h0001) begin n_fail++; $display("FAIL rstmid_mem: got %0h want 1", beats[b0]); end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; abort = 1'b0; mode16 = 1'b0; base_addr = '0; len = '0;
    rdy_all = 1'b1; rdy_3 = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_simul_write_start();
    test_mode16();
    test_wrap();
    test_backpressure();
    test_abort();
    test_write_block();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
